// File: rtl/binary_mul_9_1_bi.sv
// binary_mul_9_1_bi: signed 9x9 multiplier with a single registered output.
// Radix-4 Booth encoding of B produces five partial products, which a
// carry-save tree reduces to two vectors before a final carry-propagate add.
// Everything is kept at 17 bits, so the result is the product mod 2^17.
// The one out-of-range case, (-256)*(-256), therefore wraps to 17'h10000.
module binary_mul_9_1_bi (
    input  logic        clk,
    input  logic        rst_n,   // active-high despite the name: 1 = in reset
    input  logic        en,
    input  logic [8:0]  A,
    input  logic [8:0]  B,
    output logic [16:0] P
);

    // B with the implicit zero below bit 0 and one extra sign bit on top,
    // so five overlapping 3-bit Booth windows cover it exactly.
    logic [10:0] b_ext;
    assign b_ext = {B[8], B, 1'b0};

    // A and 2A as 10-bit signed magnitudes for the Booth selectors.
    logic [9:0] a_x1;
    logic [9:0] a_x2;
    assign a_x1 = {A[8], A};
    assign a_x2 = {A, 1'b0};

    logic [16:0] pp [5];

    // Booth digit decode and partial-product generation, one per window.
    for (genvar g = 0; g < 5; g++) begin : g_booth
        logic        hi, mid, lo;
        logic        neg, one, two;
        logic [9:0]  mag;
        logic [16:0] ext;
        logic [16:0] signed_pp;

        assign hi  = b_ext[2*g+2];
        assign mid = b_ext[2*g+1];
        assign lo  = b_ext[2*g];

        assign neg = hi;
        assign one = mid ^ lo;
        assign two = (hi & ~mid & ~lo) | (~hi & mid & lo);

        assign mag       = one ? a_x1 : (two ? a_x2 : 10'd0);
        assign ext       = {{7{mag[9]}}, mag};
        assign signed_pp = neg ? (17'd0 - ext) : ext;
        assign pp[g]     = signed_pp << (2 * g);
    end

    // 3:2 compressor layers; carry vectors are pre-shifted, bit 16 carries
    // out of the 17-bit field are discarded (mod 2^17 arithmetic).
    logic [16:0] s1, c1, s2, c2, s3, c3;

    // First layer compresses pp0..pp2, second layer pp3, pp4 and s1.
    always_comb begin
        s1 = pp[0] ^ pp[1] ^ pp[2];
        c1 = '0;
        for (int k = 1; k < 17; k++) begin
            c1[k] = (pp[0][k-1] & pp[1][k-1]) | (pp[0][k-1] & pp[2][k-1])
                  | (pp[1][k-1] & pp[2][k-1]);
        end
        s2 = pp[3] ^ pp[4] ^ s1;
        c2 = '0;
        for (int k = 1; k < 17; k++) begin
            c2[k] = (pp[3][k-1] & pp[4][k-1]) | (pp[3][k-1] & s1[k-1])
                  | (pp[4][k-1] & s1[k-1]);
        end
    end

    // Final compression layer down to a sum/carry pair.
    always_comb begin
        s3 = c1 ^ s2 ^ c2;
        c3 = '0;
        for (int k = 1; k < 17; k++) begin
            c3[k] = (c1[k-1] & s2[k-1]) | (c1[k-1] & c2[k-1])
                  | (s2[k-1] & c2[k-1]);
        end
    end

    logic [16:0] prod;
    assign prod = s3 + c3;

    logic [16:0] p_q;
    logic [16:0] p_d;

    // Next value of the output register: capture when enabled, else hold.
    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = prod;
        end
    end

    // Output register with asynchronous clear taking priority over enable.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign P = p_q;

endmodule

// File: tb/tb_binary_mul_9_1_bi.sv
// Directed bench for binary_mul_9_1_bi: reset, sign cases, wrap, enable hold,
// asynchronous reset mid-stream and a broad sweep against a behavioural model.
module tb_binary_mul_9_1_bi;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [8:0]  A;
    logic [8:0]  B;
    logic [16:0] P;

    int n_checks;
    int n_fail;

    binary_mul_9_1_bi dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model(input int a, input int b);
        logic [31:0] full;
        full = a * b;
        return full[16:0];
    endfunction

    task automatic drive(input int a, input int b);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        A = av[8:0];
        B = bv[8:0];
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        drive(5, 7);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (P !== 17'd0) begin
                $display("FAIL reset_hold: P=%h expected=%h", P, 17'd0);
                n_fail++;
            end
        end
        @(negedge clk);
        n_checks++;
        if (P !== 17'd0) begin
            $display("FAIL reset_before_release: P=%h expected=%h", P, 17'd0);
            n_fail++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (P !== 17'd35) begin
            $display("FAIL reset_release: P=%h expected=%h", P, 17'd35);
            n_fail++;
        end
    endtask

    task automatic test_signs();
        int          va [4] = '{3, -1, 255, -256};
        int          vb [4] = '{-4, -1, 255, 255};
        logic [16:0] ex [4] = '{17'h1FFF4, 17'h00001, 17'h0FE01, 17'h10100};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(va[i], vb[i]);
            @(posedge clk);
            #1;
            n_checks++;
            if (P !== ex[i]) begin
                $display("FAIL sign_case_%0d: P=%h expected=%h", i, P, ex[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        en = 1'b1;
        drive(-256, -256);
        @(posedge clk);
        #1;
        n_checks++;
        if (P !== 17'h10000) begin
            $display("FAIL overflow_wrap: P=%h expected=%h", P, 17'h10000);
            n_fail++;
        end
    endtask

    task automatic test_enable_hold();
        @(negedge clk);
        en = 1'b1;
        drive(10, 10);
        @(posedge clk);
        #1;
        n_checks++;
        if (P !== 17'd100) begin
            $display("FAIL hold_load: P=%h expected=%h", P, 17'd100);
            n_fail++;
        end
        @(negedge clk);
        en = 1'b0;
        drive(-7, 9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (P !== 17'd100) begin
                $display("FAIL hold_edge_%0d: P=%h expected=%h", i, P, 17'd100);
                n_fail++;
            end
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (P !== 17'h1FFC1) begin
            $display("FAIL hold_resume: P=%h expected=%h", P, 17'h1FFC1);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en = 1'b1;
        drive(10, 10);
        @(posedge clk);
        #1;
        n_checks++;
        if (P !== 17'd100) begin
            $display("FAIL async_preload: P=%h expected=%h", P, 17'd100);
            n_fail++;
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (P !== 17'd0) begin
            $display("FAIL async_clear: P=%h expected=%h", P, 17'd0);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        drive(3, -4);
        @(posedge clk);
        #1;
        n_checks++;
        if (P !== 17'd0) begin
            $display("FAIL async_no_enable: P=%h expected=%h", P, 17'd0);
            n_fail++;
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (P !== 17'h1FFF4) begin
            $display("FAIL async_resume: P=%h expected=%h", P, 17'h1FFF4);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int bset [20] = '{-256, -255, -200, -129, -128, -127, -64, -3, -2, -1,
                          0, 1, 2, 3, 85, 127, 128, 170, 254, 255};
        int          sweep_fail;
        logic [16:0] ex;
        sweep_fail = 0;
        en = 1'b1;
        for (int a = -256; a < 256; a++) begin
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                drive(a, bset[j]);
                ex = model(a, bset[j]);
                @(posedge clk);
                #1;
                n_checks++;
                if (P !== ex) begin
                    n_fail++;
                    sweep_fail++;
                    if (sweep_fail <= 10)
                        $display("FAIL sweep a=%0d b=%0d: P=%h expected=%h",
                                 a, bset[j], P, ex);
                end
            end
        end
        for (int i = 0; i < 4000; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(511)) - 256;
            rb = int'($urandom_range(511)) - 256;
            @(negedge clk);
            drive(ra, rb);
            ex = model(ra, rb);
            @(posedge clk);
            #1;
            n_checks++;
            if (P !== ex) begin
                n_fail++;
                sweep_fail++;
                if (sweep_fail <= 10)
                    $display("FAIL random a=%0d b=%0d: P=%h expected=%h",
                             ra, rb, P, ex);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        A        = '0;
        B        = '0;
        test_reset();
        test_signs();
        test_overflow();
        test_enable_hold();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
